// File: rtl/mvm_issue_ctrl.sv
// mvm_issue_ctrl: sequences a matrix-vector multiply over 8-element chunks.
// It walks (row, chunk) addresses row-major, pairs the returned matrix and
// vector chunks into dot-engine requests, and folds the in-order dot results
// into one signed sum per row.
module mvm_issue_ctrl #(
  parameter int IWIDTH  = 8,
  parameter int OWIDTH  = 32,
  parameter int ROW_W   = 3,
  parameter int CHUNK_W = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ROW_W:0]             num_rows,
  input  logic [CHUNK_W:0]           num_chunks,
  output logic                       busy,
  output logic                       done,
  output logic [CHUNK_W-1:0]         vmem_raddr,
  output logic [ROW_W+CHUNK_W-1:0]   mmem_raddr,
  input  logic [8*IWIDTH-1:0]        vmem_rdata,
  input  logic [8*IWIDTH-1:0]        mmem_rdata,
  output logic [8*IWIDTH-1:0]        dot_vec0,
  output logic [8*IWIDTH-1:0]        dot_vec1,
  output logic                       dot_ivalid,
  input  logic [OWIDTH-1:0]          dot_result,
  input  logic                       dot_ovalid,
  output logic [OWIDTH-1:0]          out_data,
  output logic [ROW_W-1:0]           out_row,
  output logic                       out_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned MAX_ROWS_I   = 1 << ROW_W;
  localparam int unsigned MAX_CHUNKS_I = 1 << CHUNK_W;
  localparam logic [ROW_W:0]   MAX_ROWS   = MAX_ROWS_I[ROW_W:0];
  localparam logic [CHUNK_W:0] MAX_CHUNKS = MAX_CHUNKS_I[CHUNK_W:0];
  localparam logic [ROW_W:0]   ONE_R      = {{ROW_W{1'b0}}, 1'b1};
  localparam logic [CHUNK_W:0] ONE_C      = {{CHUNK_W{1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [ROW_W:0]              rows_q, rows_d;
  logic [CHUNK_W:0]            chunks_q, chunks_d;
  logic [ROW_W-1:0]            iss_row_q, iss_row_d;
  logic [CHUNK_W-1:0]          iss_chk_q, iss_chk_d;
  logic [ROW_W-1:0]            res_row_q, res_row_d;
  logic [CHUNK_W-1:0]          res_chk_q, res_chk_d;
  logic [OWIDTH-1:0]           acc_q, acc_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        out_valid_q, out_valid_d;
  logic [OWIDTH-1:0]           out_data_q, out_data_d;
  logic [ROW_W-1:0]            out_row_q, out_row_d;
  logic [CHUNK_W-1:0]          vaddr_q, vaddr_d;
  logic [ROW_W+CHUNK_W-1:0]    maddr_q, maddr_d;
  // bit 0 marks the address cycle, bit MEM_LAT the cycle the read data lands
  logic [MEM_LAT:0]            rd_pipe_q, rd_pipe_d;

  logic [ROW_W:0]              rows_sat_s;
  logic [CHUNK_W:0]            chunks_sat_s;
  logic                        start_ok_s;
  logic                        issue_s;
  logic                        iss_chk_last_s;
  logic                        iss_last_s;
  logic                        res_take_s;
  logic                        res_chk_last_s;
  logic                        res_row_last_s;
  logic                        final_s;

  // Job acceptance, saturation and last-element detection shared by both comb blocks.
  always_comb begin
    rows_sat_s     = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    chunks_sat_s   = (num_chunks > MAX_CHUNKS) ? MAX_CHUNKS : num_chunks;
    // busy_q still high in the cycle after DONE, so a start there is ignored
    start_ok_s     = (state_q == S_IDLE) && start && !busy_q;
    issue_s        = (state_q == S_ISSUE);
    iss_chk_last_s = ({1'b0, iss_chk_q} == (chunks_q - ONE_C));
    iss_last_s     = iss_chk_last_s && ({1'b0, iss_row_q} == (rows_q - ONE_R));
    // results that show up with no job running are dropped
    res_take_s     = dot_ovalid && (state_q != S_IDLE);
    res_chk_last_s = ({1'b0, res_chk_q} == (chunks_q - ONE_C));
    res_row_last_s = ({1'b0, res_row_q} == (rows_q - ONE_R));
    final_s        = res_take_s && res_chk_last_s && res_row_last_s;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rows_q      <= {(ROW_W+1){1'b0}};
      chunks_q    <= {(CHUNK_W+1){1'b0}};
      iss_row_q   <= {ROW_W{1'b0}};
      iss_chk_q   <= {CHUNK_W{1'b0}};
      res_row_q   <= {ROW_W{1'b0}};
      res_chk_q   <= {CHUNK_W{1'b0}};
      acc_q       <= {OWIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {OWIDTH{1'b0}};
      out_row_q   <= {ROW_W{1'b0}};
      vaddr_q     <= {CHUNK_W{1'b0}};
      maddr_q     <= {(ROW_W+CHUNK_W){1'b0}};
      rd_pipe_q   <= {(MEM_LAT+1){1'b0}};
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      chunks_q    <= chunks_d;
      iss_row_q   <= iss_row_d;
      iss_chk_q   <= iss_chk_d;
      res_row_q   <= res_row_d;
      res_chk_q   <= res_chk_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      vaddr_q     <= vaddr_d;
      maddr_q     <= maddr_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  // Next-state logic for the IDLE/ISSUE/DRAIN/DONE controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          if ((rows_sat_s == {(ROW_W+1){1'b0}}) || (chunks_sat_s == {(CHUNK_W+1){1'b0}})) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (iss_last_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (final_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values: address walk, read pipeline, accumulation.
  always_comb begin
    rows_d      = rows_q;
    chunks_d    = chunks_q;
    iss_row_d   = iss_row_q;
    iss_chk_d   = iss_chk_q;
    res_row_d   = res_row_q;
    res_chk_d   = res_chk_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    vaddr_d     = vaddr_q;
    maddr_d     = maddr_q;
    rd_pipe_d   = {rd_pipe_q[MEM_LAT-1:0], issue_s};
    // done follows the single DONE-state cycle; busy is held through it
    done_d      = (state_q == S_DONE);
    busy_d      = (state_d != S_IDLE) || (state_q == S_DONE);

    if (start_ok_s) begin
      rows_d    = rows_sat_s;
      chunks_d  = chunks_sat_s;
      iss_row_d = {ROW_W{1'b0}};
      iss_chk_d = {CHUNK_W{1'b0}};
      res_row_d = {ROW_W{1'b0}};
      res_chk_d = {CHUNK_W{1'b0}};
      acc_d     = {OWIDTH{1'b0}};
    end else if (issue_s) begin
      vaddr_d = iss_chk_q;
      maddr_d = {iss_row_q, iss_chk_q};
      if (iss_chk_last_s) begin
        iss_chk_d = {CHUNK_W{1'b0}};
        iss_row_d = iss_row_q + {{(ROW_W-1){1'b0}}, 1'b1};
      end else begin
        iss_chk_d = iss_chk_q + {{(CHUNK_W-1){1'b0}}, 1'b1};
        iss_row_d = iss_row_q;
      end
    end else begin
      vaddr_d = vaddr_q;
      maddr_d = maddr_q;
    end

    if (res_take_s) begin
      if (res_chk_q == {CHUNK_W{1'b0}}) begin
        acc_d = dot_result;
      end else begin
        acc_d = acc_q + dot_result;
      end
      if (res_chk_last_s) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_d;
        out_row_d   = res_row_q;
        res_chk_d   = {CHUNK_W{1'b0}};
        res_row_d   = res_row_q + {{(ROW_W-1){1'b0}}, 1'b1};
      end else begin
        out_valid_d = 1'b0;
        res_chk_d   = res_chk_q + {{(CHUNK_W-1){1'b0}}, 1'b1};
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_row    = out_row_q;
  assign vmem_raddr = vaddr_q;
  assign mmem_raddr = maddr_q;
  assign dot_ivalid = rd_pipe_q[MEM_LAT];
  // read data is only meaningful in the cycle it lands; zero elsewhere
  assign dot_vec0   = dot_ivalid ? mmem_rdata : {(8*IWIDTH){1'b0}};
  assign dot_vec1   = dot_ivalid ? vmem_rdata : {(8*IWIDTH){1'b0}};

endmodule

// File: tb/tb_mvm_issue_ctrl.sv
// Directed bench for mvm_issue_ctrl with synchronous memory and dot-engine models.
module tb_mvm_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_rows = 4'd0;
  logic [2:0]  num_chunks = 3'd0;
  logic        busy, done, dot_ivalid, out_valid;
  logic [1:0]  vmem_raddr;
  logic [4:0]  mmem_raddr;
  logic [63:0] vmem_rdata, mmem_rdata, dot_vec0, dot_vec1;
  logic [31:0] dot_result, out_data;
  logic        dot_ovalid;
  logic [2:0]  out_row;

  logic [63:0] vmem [0:3];
  logic [63:0] mmem [0:31];
  logic        eng_ov = 1'b0;
  logic [31:0] eng_res = 32'd0;
  logic        force_ov = 1'b0;
  logic [31:0] force_val = 32'd1000;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t0 = 0;
  int clr_gen = 0;

  // monitor state (written only by the monitor process)
  int seen_gen = 0;
  int iv_count, iv_first, iv_last, done_cnt, done_cyc, busy_cnt;
  logic [4:0] prev_maddr;
  logic [1:0] prev_vaddr;
  logic [4:0]  q_maddr [$];
  logic [1:0]  q_vaddr [$];
  logic [31:0] q_data  [$];
  logic [2:0]  q_row   [$];
  int          q_ocyc  [$];

  mvm_issue_ctrl dut (
    .clk(clk), .rst(rst_n), .start(start), .num_rows(num_rows), .num_chunks(num_chunks),
    .busy(busy), .done(done), .vmem_raddr(vmem_raddr), .mmem_raddr(mmem_raddr),
    .vmem_rdata(vmem_rdata), .mmem_rdata(mmem_rdata), .dot_vec0(dot_vec0), .dot_vec1(dot_vec1),
    .dot_ivalid(dot_ivalid), .dot_result(dot_result), .dot_ovalid(dot_ovalid),
    .out_data(out_data), .out_row(out_row), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dot8(input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] s;
    logic signed [7:0]  ea, eb;
    s = 32'sd0;
    for (int i = 0; i < 8; i++) begin
      ea = a[8*i +: 8];
      eb = b[8*i +: 8];
      s = s + 32'(ea) * 32'(eb);
    end
    return s;
  endfunction

  // cycle counter, memories with one-cycle read latency, one-cycle dot engine
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    vmem_rdata <= vmem[vmem_raddr];
    mmem_rdata <= mmem[mmem_raddr];
    eng_ov     <= dot_ivalid;
    eng_res    <= dot8(dot_vec0, dot_vec1);
  end

  assign dot_ovalid = eng_ov | force_ov;
  assign dot_result = force_ov ? force_val : eng_res;

  // event recorder sampled on the falling edge
  always @(negedge clk) begin
    if (seen_gen != clr_gen) begin
      seen_gen = clr_gen;
      iv_count = 0; iv_first = -1; iv_last = -1;
      done_cnt = 0; done_cyc = -1; busy_cnt = 0;
      q_maddr.delete(); q_vaddr.delete(); q_data.delete(); q_row.delete(); q_ocyc.delete();
    end
    if (dot_ivalid) begin
      if (iv_count == 0) iv_first = cyc;
      iv_last = cyc;
      iv_count++;
      q_maddr.push_back(prev_maddr);
      q_vaddr.push_back(prev_vaddr);
    end
    if (out_valid) begin
      q_data.push_back(out_data);
      q_row.push_back(out_row);
      q_ocyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    prev_maddr = mmem_raddr;
    prev_vaddr = vmem_raddr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] mbyte, input logic [7:0] vbyte);
    for (int i = 0; i < 32; i++) mmem[i] = {8{mbyte}};
    for (int i = 0; i < 4; i++) vmem[i] = {8{vbyte}};
  endtask

  task automatic start_job(input logic [3:0] r, input logic [2:0] c);
    clr_gen++;
    @(negedge clk);
    num_rows = r; num_chunks = c; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 300), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fill(8'd0, 8'd0);
    repeat (3) @(negedge clk);
    #1;
    // reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ivalid", 64'(dot_ivalid), 64'd0);
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_maddr", 64'(mmem_raddr), 64'd0);
    chk("rst_odata", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1x1: matrix ones, vector 1..8 -> 36
    fill(8'd1, 8'd0);
    vmem[0] = 64'h0807060504030201;
    start_job(4'd1, 3'd1);
    wait_done("t1");
    chk("t1_iv_lat", 64'(iv_first - t0), 64'd3);
    chk("t1_iv_cnt", 64'(iv_count), 64'd1);
    chk("t1_ov_cnt", 64'(q_data.size()), 64'd1);
    chk("t1_data", 64'(q_data[0]), 64'd36);
    chk("t1_row", 64'(q_row[0]), 64'd0);
    chk("t1_done_at", 64'(done_cyc - q_ocyc[0]), 64'd1);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_busy_cnt", 64'(busy_cnt), 64'd6);

    // 2x2: row0 ones, row1 twos, vector threes -> 48, 96
    fill(8'd1, 8'd3);
    for (int i = 4; i < 8; i++) mmem[i] = {8{8'd2}};
    start_job(4'd2, 3'd2);
    wait_done("t2");
    chk("t2_iv_cnt", 64'(iv_count), 64'd4);
    chk("t2_iv_first", 64'(iv_first - t0), 64'd3);
    chk("t2_iv_last", 64'(iv_last - t0), 64'd6);
    chk("t2_maddr0", 64'(q_maddr[0]), 64'd0);
    chk("t2_maddr1", 64'(q_maddr[1]), 64'd1);
    chk("t2_maddr2", 64'(q_maddr[2]), 64'd4);
    chk("t2_maddr3", 64'(q_maddr[3]), 64'd5);
    chk("t2_vaddr1", 64'(q_vaddr[1]), 64'd1);
    chk("t2_vaddr2", 64'(q_vaddr[2]), 64'd0);
    chk("t2_ov_cnt", 64'(q_data.size()), 64'd2);
    chk("t2_data0", 64'(q_data[0]), 64'd48);
    chk("t2_row0", 64'(q_row[0]), 64'd0);
    chk("t2_data1", 64'(q_data[1]), 64'd96);
    chk("t2_row1", 64'(q_row[1]), 64'd1);

    // 1x1 of -128 everywhere -> 131072
    fill(8'h80, 8'h80);
    start_job(4'd1, 3'd1);
    wait_done("t3");
    chk("t3_data", 64'(q_data[0]), 64'd131072);

    // saturation: 15 rows -> 8, 7 chunks -> 4; each row 524288
    start_job(4'd15, 3'd7);
    wait_done("t4");
    chk("t4_iv_cnt", 64'(iv_count), 64'd32);
    chk("t4_ov_cnt", 64'(q_data.size()), 64'd8);
    chk("t4_data0", 64'(q_data[0]), 64'd524288);
    chk("t4_data7", 64'(q_data[7]), 64'd524288);
    chk("t4_row7", 64'(q_row[7]), 64'd7);

    // zero rows: nothing issued, done two cycles after start, busy two cycles
    start_job(4'd0, 3'd2);
    wait_done("t5");
    chk("t5_iv_cnt", 64'(iv_count), 64'd0);
    chk("t5_done_at", 64'(done_cyc - t0), 64'd2);
    chk("t5_busy_cnt", 64'(busy_cnt), 64'd2);
    chk("t5_ov_cnt", 64'(q_data.size()), 64'd0);

    // zero chunks
    start_job(4'd3, 3'd0);
    wait_done("t6");
    chk("t6_iv_cnt", 64'(iv_count), 64'd0);
    chk("t6_done_cnt", 64'(done_cnt), 64'd1);

    // start pulsed mid-ISSUE is ignored
    fill(8'd1, 8'd3);
    for (int i = 4; i < 8; i++) mmem[i] = {8{8'd2}};
    start_job(4'd2, 3'd2);
    num_rows = 4'd1; num_chunks = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t7");
    repeat (6) @(negedge clk);
    chk("t7_iv_cnt", 64'(iv_count), 64'd4);
    chk("t7_ov_cnt", 64'(q_data.size()), 64'd2);
    chk("t7_data1", 64'(q_data[1]), 64'd96);
    chk("t7_done_cnt", 64'(done_cnt), 64'd1);

    // reset during DRAIN, then stray results while idle
    start_job(4'd2, 3'd2);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t8_busy", 64'(busy), 64'd0);
    chk("t8_ivalid", 64'(dot_ivalid), 64'd0);
    chk("t8_vec0", dot_vec0, 64'd0);
    chk("t8_maddr", 64'(mmem_raddr), 64'd0);
    chk("t8_odata", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_gen++;
    @(negedge clk);
    force_ov = 1'b1;
    repeat (2) @(negedge clk);
    force_ov = 1'b0;
    repeat (4) @(negedge clk);
    chk("t8_no_ov", 64'(q_data.size()), 64'd0);
    chk("t8_no_done", 64'(done_cnt), 64'd0);
    fill(8'd1, 8'd0);
    vmem[0] = 64'h0807060504030201;
    start_job(4'd1, 3'd1);
    wait_done("t8b");
    chk("t8_after_data", 64'(q_data[0]), 64'd36);
    chk("t8_after_row", 64'(q_row[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvm_issue_ctrl.md
MVM_ISSUE_CTRL -- requirements
Module: mvm_issue_ctrl

Interface
REQ-001 SHALL have parameters: IWIDTH=8 (element width); OWIDTH=32 (result/accumulator width); ROW_W=3 (row index width); CHUNK_W=2 (8-element chunk index width); MEM_LAT=1 (memory read latency, fixed).
REQ-002 Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request.
- num_rows  in  ROW_W+1  row count, 0..2^ROW_W.
- num_chunks  in  CHUNK_W+1  8-element chunks per row, 0..2^CHUNK_W.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- vmem_raddr  out  CHUNK_W  vector memory read address.
- mmem_raddr  out  ROW_W+CHUNK_W  matrix memory read address.
- vmem_rdata  in  8*IWIDTH  vector chunk, valid 1 cycle after address.
- mmem_rdata  in  8*IWIDTH  matrix chunk, valid 1 cycle after address.
- dot_vec0  out  8*IWIDTH  matrix chunk to dot engine.
- dot_vec1  out  8*IWIDTH  vector chunk to dot engine.
- dot_ivalid  out  1  dot request valid.
- dot_result  in  OWIDTH  signed dot engine result.
- dot_ovalid  in  1  dot result valid; in order, no stall.
- out_data  out  OWIDTH  signed row sum.
- out_row  out  ROW_W  row index of out_data.
- out_valid  out  1  out_data/out_row valid, one cycle per row.

Function
REQ-003 SHALL implement FSM IDLE, ISSUE, DRAIN, DONE.
REQ-004 IDLE: start=1 latches num_rows/num_chunks; values above 2^ROW_W / 2^CHUNK_W saturate to the maximum.
REQ-005 If either latched count is 0, SHALL go IDLE->DONE and issue nothing.
REQ-006 Otherwise IDLE->ISSUE; busy=1 in every state except IDLE.
REQ-007 ISSUE: one read per cycle, no bubbles, row-major (c = 0..num_chunks-1 within r = 0..num_rows-1).
- vmem_raddr=c; mmem_raddr={r,c}; addresses are registered outputs.
REQ-008 Issued reads SHALL produce dot_ivalid=1 exactly MEM_LAT cycles after the address cycle.
- dot_vec0=mmem_rdata and dot_vec1=vmem_rdata in that cycle.
- dot_ivalid=0 otherwise.
REQ-009 After the last (r,c) address is issued, SHALL go ISSUE->DRAIN.
REQ-010 On each dot_ovalid=1, SHALL consume dot_result.
- acc = dot_result when result chunk counter = 0, else acc + dot_result.
- Sums wrap modulo 2^OWIDTH.
REQ-011 When the result chunk counter = num_chunks-1, SHALL pulse out_valid=1 the cycle after dot_ovalid.
- out_data = final sum; out_row = result row counter.
- Chunk counter then resets to 0 and row counter increments.
REQ-012 DRAIN->DONE SHALL occur the cycle after the final row's out_valid.
- done=1 for exactly that cycle, then DONE->IDLE.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 dot_ovalid in IDLE SHALL be ignored (no counter or accumulator change).
REQ-015 Latency: start accepted at edge T gives first address at T+1 and first dot_ivalid at T+2.
- Issue span is num_rows*num_chunks consecutive cycles.
REQ-016 dot_result SHALL be treated as sign-extended OWIDTH; no internal narrowing.

Reset
REQ-017 rst=0 SHALL asynchronously force:
- state IDLE.
- busy, done, dot_ivalid, out_valid = 0.
- all addresses, counters, acc, out_data, out_row, dot_vec0, dot_vec1 = 0.
REQ-018 Reset mid-job SHALL abandon the job; results arriving after release are ignored per REQ-014.

Verification
REQ-019 1 row x 1 chunk, matrix all 1, vector 1..8 -> dot_ivalid at T+2; out_data=36, out_row=0, one out_valid; done next cycle.
REQ-020 2 rows x 2 chunks, matrix row0 all 1, row1 all 2, vector all 3 -> addresses {0,0},{0,1},{1,0},{1,1} on consecutive cycles; out_data 48 (row 0) then 96 (row 1).
REQ-021 1x1 with all elements -128 (model dot engine) -> out_data=131072; 4 chunks -> 524288.
REQ-022 start with num_rows=0 -> no dot_ivalid; done pulses 2 cycles after start; busy=1 for 2 cycles only.
REQ-023 start pulsed again mid-ISSUE -> ignored; only original outputs appear.
REQ-024 rst=0 during DRAIN, then a pending dot_ovalid arrives -> all outputs 0 immediately; no out_valid; next start runs normally.
